// File: rtl/rst_seq_ctrl_if.sv
// Reset sequencer bundle: software reset request, per-stage acks and the
// sequenced reset outputs with status. The sequencer is the slave side.
//
// Handshake: i_sw_rst_req is a one-clock request that the sequencer samples on
// a rising edge; no acknowledge is returned other than o_busy rising.
// i_stage_ack[k] is the stage's "init done" indication and is sampled only
// while the sequencer is waiting on stage k (whose o_rst_n[k] is already 1).
// It may be a level or a single-clock pulse. Any other ack bit is ignored.
interface rst_seq_ctrl_if #(
  parameter int N_STAGES = 4
);
  logic                i_sw_rst_req;
  logic [N_STAGES-1:0] i_stage_ack;
  logic [N_STAGES-1:0] o_rst_n;
  logic                o_ready;
  logic                o_busy;
  logic                o_timeout_err;
  logic [2:0]          o_state;

  modport master (
    output i_sw_rst_req, i_stage_ack,
    input  o_rst_n, o_ready, o_busy, o_timeout_err, o_state
  );

  modport slave (
    input  i_sw_rst_req, i_stage_ack,
    output o_rst_n, o_ready, o_busy, o_timeout_err, o_state
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: asynchronous assert, synchronized release, then releases
// N_STAGES active-low resets one at a time, waiting for each stage's ack.
// A software request in DELAY/WAIT_ACK/RUN re-asserts everything and restarts.
module rst_seq_ctrl #(
  parameter int N_STAGES     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int STAGE_DLY    = 16,
  parameter int ACK_TIMEOUT  = 64,
  parameter int MIN_SW_PULSE = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  rst_seq_ctrl_if.slave bus
);

  localparam int MAXC = (STAGE_DLY > ACK_TIMEOUT)
                        ? ((STAGE_DLY > MIN_SW_PULSE) ? STAGE_DLY : MIN_SW_PULSE)
                        : ((ACK_TIMEOUT > MIN_SW_PULSE) ? ACK_TIMEOUT : MIN_SW_PULSE);
  localparam int CW = $clog2(MAXC + 1);
  localparam int KW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CW-1:0] DLY_LAST = CW'(STAGE_DLY - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] SW_LAST  = CW'(MIN_SW_PULSE - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(N_STAGES - 1);

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    DELAY    = 3'd1,
    WAIT_ACK = 3'd2,
    RUN      = 3'd3,
    SW_RST   = 3'd4
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [KW-1:0]          k;
  logic [N_STAGES-1:0]    rst_n_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   err_q;
  logic [SYNC_STAGES-2:0] sync_q;
  logic                   rst_sync;

  // Release synchronizer; the FSM state register acts as its final stage, so
  // HOLD is left on the SYNC_STAGES-th rising edge after i_rst falls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '1;
    else       sync_q <= sync_q << 1;
  end

  assign rst_sync = sync_q[SYNC_STAGES-2];

  // Sequencing FSM with registered reset/status outputs. Each counter is
  // reloaded to zero on state entry and compared against (period - 1).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= HOLD;
      cnt     <= '0;
      k       <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (!rst_sync) begin
            state <= DELAY;
            cnt   <= '0;
            k     <= '0;
          end
        end
        DELAY: begin
          if (bus.i_sw_rst_req) begin
            state   <= SW_RST;
            cnt     <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else if (cnt == DLY_LAST) begin
            rst_n_q[k] <= 1'b1;
            state      <= WAIT_ACK;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_ACK: begin
          if (bus.i_sw_rst_req) begin
            state   <= SW_RST;
            cnt     <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else if (bus.i_stage_ack[k] || (cnt == TO_LAST)) begin
            // A missed ack is flagged but the stage is treated as acked.
            if (!bus.i_stage_ack[k]) err_q <= 1'b1;
            cnt <= '0;
            if (k == K_LAST) begin
              state <= RUN;
            end else begin
              k     <= k + 1'b1;
              state <= DELAY;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (bus.i_sw_rst_req) begin
            state   <= SW_RST;
            cnt     <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        SW_RST: begin
          // Requests arriving here are ignored; the pulse length is fixed.
          if (cnt == SW_LAST) begin
            state <= DELAY;
            cnt   <= '0;
            k     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

  assign bus.o_rst_n       = rst_n_q;
  assign bus.o_ready       = ready_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_timeout_err = err_q;
  assign bus.o_state       = state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed scenarios pinned with literal edge numbers,
// then randomized acks / software requests / async glitches, all checked every
// cycle against a deadline-based model of the sequencing rules.
module tb_rst_seq_ctrl;
  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DLY  = 16;
  localparam int TO   = 64;
  localparam int MSW  = 8;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst;
  always #10 i_clk = ~i_clk;

  rst_seq_ctrl_if #(.N_STAGES(N)) bus ();

  rst_seq_ctrl #(
    .N_STAGES(N), .SYNC_STAGES(SYNC), .STAGE_DLY(DLY),
    .ACK_TIMEOUT(TO), .MIN_SW_PULSE(MSW)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  int n_cmp;
  int n_fail;

  // ---------------- behavioural model ----------------
  // Phase codes are the published debug codes: 0 hold, 1 gap before a release,
  // 2 waiting for an ack, 3 run, 4 software reset pulse. Time is the count of
  // rising edges since i_rst fell; each phase ends at an absolute deadline.
  int   m_t, m_ph, m_rel, m_due;
  logic m_ready, m_busy, m_err;

  task automatic model_sw();
    m_rel   = 0;
    m_ready = 1'b0;
    m_busy  = 1'b1;
    m_ph    = 4;
    m_due   = m_t + MSW;
  endtask

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_t = 0; m_ph = 0; m_rel = 0; m_due = -1;
      m_ready = 1'b0; m_busy = 1'b1; m_err = 1'b0;
    end else begin
      m_t++;
      case (m_ph)
        0: if (m_t >= SYNC) begin m_ph = 1; m_due = m_t + DLY; end
        1: begin
          if (bus.i_sw_rst_req) model_sw();
          else if (m_t == m_due) begin m_rel++; m_ph = 2; m_due = m_t + TO; end
        end
        2: begin
          if (bus.i_sw_rst_req) model_sw();
          else if (bus.i_stage_ack[m_rel-1] || m_t == m_due) begin
            if (!bus.i_stage_ack[m_rel-1]) m_err = 1'b1;
            if (m_rel == N) m_ph = 3;
            else begin m_ph = 1; m_due = m_t + DLY; end
          end
        end
        3: begin
          if (bus.i_sw_rst_req) model_sw();
          else begin m_ready = 1'b1; m_busy = 1'b0; end
        end
        default: if (m_t == m_due) begin m_ph = 1; m_due = m_t + DLY; end
      endcase
    end
  end

  // ---------------- stage ack driver ----------------
  int            ack_dly[N];
  int            acnt[N];
  logic [N-1:0]  auto_ack;
  logic          force_ack;
  logic          noise_en;
  logic          pulse_mode;

  always @(negedge i_clk) begin
    logic [N-1:0] noise;
    noise = N'($urandom) & N'($urandom) & N'($urandom);
    for (int k = 0; k < N; k++) begin
      if (bus.o_rst_n[k] !== 1'b1) begin
        acnt[k] = 0;
        auto_ack[k] = 1'b0;
      end else begin
        acnt[k]++;
        auto_ack[k] = pulse_mode ? (acnt[k] == ack_dly[k]) : (acnt[k] >= ack_dly[k]);
      end
    end
    bus.i_stage_ack = auto_ack | {N{force_ack}} | (noise_en ? noise : '0);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [N-1:0] em;
    forever begin
      @(negedge i_clk);
      em = '0;
      for (int i = 0; i < N; i++) if (i < m_rel) em[i] = 1'b1;
      n_cmp++;
      if (bus.o_rst_n !== em || bus.o_ready !== m_ready || bus.o_busy !== m_busy ||
          bus.o_timeout_err !== m_err || bus.o_state !== 3'(m_ph)) begin
        n_fail++;
        $display("FAIL cycle t=%0d: rst_n/ready/busy/err/state got %b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
                 m_t, bus.o_rst_n, bus.o_ready, bus.o_busy, bus.o_timeout_err, bus.o_state,
                 em, m_ready, m_busy, m_err, m_ph);
      end
    end
  endtask

  // sel 0: o_rst_n[k] high, 1: o_ready high, 2: o_timeout_err high
  task automatic wait_out(input int sel, input int k, input int maxc, input string name,
                          output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge i_clk);
      if ((sel == 0 && bus.o_rst_n[k] === 1'b1) || (sel == 1 && bus.o_ready === 1'b1) ||
          (sel == 2 && bus.o_timeout_err === 1'b1)) begin
        at = m_t;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: not seen within %0d cycles", name, maxc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic power_up(input int hold);
    i_rst = 1'b1;
    repeat (hold) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic sw_pulse(output int e);
    bus.i_sw_rst_req = 1'b1;
    e = m_t + 1;
    @(negedge i_clk);
    bus.i_sw_rst_req = 1'b0;
  endtask

  task automatic set_acks(input int d);
    for (int k = 0; k < N; k++) ack_dly[k] = d;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int at, e, prev;
    n_cmp = 0;
    n_fail = 0;
    bus.i_sw_rst_req = 1'b0;
    force_ack = 1'b0;
    noise_en = 1'b0;
    pulse_mode = 1'b0;
    set_acks(3);
    i_rst = 1'b0;
    #1 i_rst = 1'b1;
    fork monitor(); join_none

    // reset values
    repeat (3) @(negedge i_clk);
    chk("reset_rst_n", 32'(bus.o_rst_n), 0);
    chk("reset_ready", 32'(bus.o_ready), 0);
    chk("reset_busy",  32'(bus.o_busy), 1);
    chk("reset_err",   32'(bus.o_timeout_err), 0);
    chk("reset_state", 32'(bus.o_state), 0);

    // 1. power-up, ack 3 clocks after each release
    power_up(97);
    wait_out(0, 0, 40, "t1_rel0", at); chk("t1_rel0", at, 18);
    chk("pin_model_rel", m_rel, 1);
    wait_out(0, 1, 40, "t1_rel1", at); chk("t1_rel1", at, 37);
    wait_out(0, 2, 40, "t1_rel2", at); chk("t1_rel2", at, 56);
    wait_out(0, 3, 40, "t1_rel3", at); chk("t1_rel3", at, 75);
    wait_out(1, 0, 20, "t1_ready", at); chk("t1_ready", at, 79);

    // 2. async reset pulse while o_rst_n = 0011
    power_up(5);
    wait_out(0, 1, 60, "t2_rel1", at); chk("t2_rel1", at, 37);
    #2 i_rst = 1'b1;
    #1;
    chk("t2_async_rst_n", 32'(bus.o_rst_n), 0);
    chk("t2_async_state", 32'(bus.o_state), 0);
    #3 i_rst = 1'b0;
    wait_out(0, 0, 40, "t2_restart_rel0", at); chk("t2_restart_rel0", at, 18);
    wait_out(1, 0, 120, "t2_ready", at);

    // 3. stage 2 never acks
    ack_dly[2] = 1000000;
    power_up(5);
    wait_out(0, 2, 80, "t3_rel2", at); chk("t3_rel2", at, 56);
    wait_out(2, 0, 90, "t3_err", at);  chk("t3_err", at, 120);
    wait_out(0, 3, 40, "t3_rel3", at); chk("t3_rel3", at, 136);
    wait_out(1, 0, 20, "t3_ready", at); chk("t3_ready", at, 140);

    // 4. software reset from RUN keeps the sticky error
    set_acks(3);
    repeat (2) @(negedge i_clk);
    sw_pulse(e);
    chk("t4_rst_n", 32'(bus.o_rst_n), 0);
    chk("t4_ready", 32'(bus.o_ready), 0);
    chk("t4_busy",  32'(bus.o_busy), 1);
    chk("t4_state", 32'(bus.o_state), 4);
    chk("t4_err",   32'(bus.o_timeout_err), 1);
    wait_out(0, 0, 40, "t4_rel0", at); chk("t4_rel0", at, e + 24);
    wait_out(1, 0, 120, "t4_ready", at);

    // 5. acks held high from before release; sw request inside the pulse
    force_ack = 1'b1;
    power_up(5);
    wait_out(0, 0, 40, "t5_rel0", at); chk("t5_rel0", at, 18);
    prev = at;
    for (int k = 1; k < N; k++) begin
      wait_out(0, k, 40, "t5_rel", at);
      chk("t5_gap", at - prev, DLY + 1);
      prev = at;
    end
    wait_out(1, 0, 10, "t5_ready", at);
    sw_pulse(e);
    repeat (2) @(negedge i_clk);
    sw_pulse(prev);
    wait_out(0, 0, 40, "t5_sw_rel0", at); chk("t5_sw_rel0", at, e + 24);
    force_ack = 1'b0;

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) ack_dly[k] = $urandom_range(1, 80);
      pulse_mode = 1'($urandom_range(0, 1));
      noise_en   = 1'($urandom_range(0, 1));
      power_up($urandom_range(2, 20));
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 149) == 0) begin
          sw_pulse(e);
        end else if ($urandom_range(0, 399) == 0) begin
          #2 i_rst = 1'b1;
          #4 i_rst = 1'b0;
          @(negedge i_clk);
        end else begin
          @(negedge i_clk);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
